// File: rtl/stream_rr_arbiter.sv
// Packet-locked round-robin arbiter feeding one registered valid/ready stage.
// A grant is held from the first beat of a packet until its last beat is taken.
module stream_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    localparam int ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            in_valid,
    output logic [NUM_REQ-1:0]            in_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_REQ-1:0]            in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_last,
    output logic [ID_WIDTH-1:0]           out_id
);

    localparam int IW1 = ID_WIDTH + 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                state, state_nx;
    logic [ID_WIDTH-1:0]   rr_ptr, rr_nx;
    logic [ID_WIDTH-1:0]   grant, grant_nx;
    logic [ID_WIDTH-1:0]   win_id, sel_id;
    logic                  win_found;
    logic                  sel_valid, sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  stage_ready, accept;

    function automatic logic [IW1-1:0] wrap_add(
        input logic [ID_WIDTH-1:0] p,
        input int                  k
    );
        logic [IW1-1:0] s;
        s = {1'b0, p} + IW1'(k);
        if (s >= IW1'(NUM_REQ))
            s = s - IW1'(NUM_REQ);
        return s;
    endfunction

    function automatic logic [ID_WIDTH-1:0] next_id(
        input logic [ID_WIDTH-1:0] p
    );
        return (p == ID_WIDTH'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    assign stage_ready = !out_valid || out_ready;

    // Descending scan: the lowest offset from rr_ptr is written last and wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (in_valid[i] && (IW1'(i) == wrap_add(rr_ptr, k))) begin
                    win_found = 1'b1;
                    win_id    = ID_WIDTH'(i);
                end
            end
        end
    end

    always_comb begin
        sel_id    = (state == LOCKED) ? grant : win_id;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        in_ready  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_WIDTH'(i) == sel_id) begin
                sel_valid   = in_valid[i];
                sel_last    = in_last[i];
                sel_data    = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                in_ready[i] = !rst && stage_ready
                              && ((state == LOCKED) || win_found);
            end
        end
    end

    assign accept = !rst && sel_valid && stage_ready;

    always_comb begin
        state_nx = state;
        rr_nx    = rr_ptr;
        grant_nx = grant;
        if (accept) begin
            if (sel_last) begin
                state_nx = IDLE;
                rr_nx    = next_id(sel_id);
            end else begin
                state_nx = LOCKED;
                grant_nx = sel_id;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            grant  <= '0;
        end else begin
            state  <= state_nx;
            rr_ptr <= rr_nx;
            grant  <= grant_nx;
        end
    end

    // A new beat overwrites a draining one, so there is no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_id    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= sel_last;
            out_id    <= sel_id;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
Shares one registered valid/ready output stream among NUM_REQ upstream requesters using packet-locked round-robin arbitration. A grant is held from the first beat of a packet until its last beat is accepted, so packets are never interleaved. The output side is a single registered pipeline stage with full-throughput backpressure handling. It sits in front of shared downstream pipeline stages, for example a common processing lane fed by several sources.

Parameters:
NUM_REQ, 4, number of requesters (≥1)
DATA_WIDTH, 32, beat data width
ID_WIDTH (localparam), max(1,$clog2(NUM_REQ)), width of the grant index

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  NUM_REQ  per-requester beat valid
in_ready  out  NUM_REQ  per-requester beat accepted (one-hot or zero)
in_data  in  NUM_REQ*DATA_WIDTH  flattened beat data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
in_last  in  NUM_REQ  per-requester last beat of packet
out_valid  out  1  registered output valid
out_ready  in  1  downstream ready
out_data  out  DATA_WIDTH  registered output data
out_last  out  1  registered last flag
out_id  out  ID_WIDTH  index of the requester that produced the current output beat

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, out_valid=0, out_data=0, out_last=0, out_id=0. in_ready=0 for all requesters while rst is high.
- Output stage: stage_ready = !out_valid | out_ready. On an accepted input beat, out_data, out_last and out_id load, and out_valid is set to 1. When out_valid&out_ready is true and no beat is accepted, out_valid clears. Latency from input handshake to out_valid is 1 cycle. Sustained throughput is 1 beat/cycle.
- IDLE: the winner is the first i with in_valid[i]=1, searching circularly from rr_ptr (rr_ptr, rr_ptr+1, … wrapping at NUM_REQ-1 to 0). in_ready[winner]=stage_ready; all other in_ready bits are 0. If no in_valid is set, all in_ready bits are 0 and the state does not change.
  - Winner beat accepted with in_last=1: stay in IDLE, rr_ptr=winner+1 mod NUM_REQ.
  - Winner beat accepted with in_last=0: go to LOCKED, grant=winner.
  - Winner not accepted (stage full): no state change; arbitration is re-evaluated next cycle.
- LOCKED: in_ready[grant]=stage_ready; all others are 0. A beat is accepted when in_valid[grant]&stage_ready.
  - Accepted beat with in_last=1: go to IDLE, rr_ptr=grant+1 mod NUM_REQ.
  - Granted requester deasserts valid mid-packet: remain LOCKED indefinitely; there is no timeout.
- in_ready never has more than one bit set. A single-beat packet (in_last on the first beat) never enters LOCKED.
- Simultaneous accept and drain in the same cycle: the new beat replaces the old one, out_valid stays 1, and no bubble is inserted.
- Upstream protocol: once in_valid[i] is asserted, it stays asserted with stable data until accepted. The bench checks this with an assertion; the block does not enforce it.
- Reset mid-packet: the in-flight output beat and the lock are discarded, and the block restarts in IDLE with rr_ptr=0.
- NUM_REQ=1: the block degenerates to a single pipeline register; out_id is always 0.
- Assertions:
  - $onehot0(in_ready).
  - out_valid&!out_ready |=> stable out_valid, out_data, out_last and out_id.
  - Within a packet on the output, out_id does not change until out_last has been handshaken.

Test Plan:
1. NUM_REQ=4, all in_valid=1, every packet is 1 beat, out_ready=1 → out_id sequence 0,1,2,3,0,1; first out_valid 1 cycle after reset release plus 1 cycle; one beat per cycle.
2. Req1 sends a 3-beat packet (data 0x11,0x12,0x13, last on 0x13); req2 asserts valid at beat 2 → output 0x11,0x12,0x13 with out_id=1, then req2 data with out_id=2; in_ready[2]=0 until 0x13 is accepted.
3. Backpressure: out_ready=0 for 5 cycles while req0 holds 0xA5 → out_data=0xA5 is stable and out_valid=1 throughout; in_ready[0]=0 after the first beat is registered; no beat is lost or duplicated after out_ready=1.
4. Wrap: rr_ptr=3 (after req2 completes), in_valid=4'b1001 → req3 is granted first and rr_ptr becomes 0; then req0 is granted.
5. Req0 is locked after beat 0x01 (not last), then drops valid for 4 cycles while req1 is valid → in_ready[1] stays 0 and no output beats occur; req0 resumes with 0x02 (last) → req1 is then granted.
6. Assert rst while LOCKED with out_valid=1 → out_valid=0, out_data=0, out_id=0 immediately (asynchronously); after release, req0 wins first despite the prior pointer.
